// File: rtl/wrr_lock_arbiter_pkg.sv
// Shared definitions for the weighted round-robin lock arbiter.
//   state_e      : arbiter FSM state encoding (ST_IDLE, ST_GRANT)
//   clog2        : ceiling log2, used to size grant indices
//   weight_field : extracts one burst weight from the packed weight bus
package wrr_lock_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Widest packed weight bus weight_field can accept.
    localparam int WEIGHT_VEC_MAX = 256;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A zero weight would give a requester no turn at all, so it is read as 1.
    function automatic logic [31:0] weight_field(
        input logic [WEIGHT_VEC_MAX-1:0] weights,
        input int                        idx,
        input int                        field_w
    );
        logic [WEIGHT_VEC_MAX-1:0] shifted;
        logic [31:0]               f;
        shifted = weights >> (idx * field_w);
        f = shifted[31:0] & ((32'd1 << field_w) - 32'd1);
        if (f == 32'd0) begin
            f = 32'd1;
        end
        return f;
    endfunction

endpackage

// File: rtl/wrr_lock_arbiter_if.sv
// Bus between WIDTH requesting masters and the arbiter.
//   request     : per-requester request level
//   ack         : shared resource finished the granted transaction
//   weight      : packed burst weights, field i = [i*WEIGHT_W +: WEIGHT_W]
//   grant       : one-hot grant or zero
//   grant_valid : OR of grant
//   grant_idx   : binary index of the granted requester
//   credit_left : transactions left in the current burst, current included
// Modports: master = requester/resource side, slave = arbiter side.
interface wrr_lock_arbiter_if
    import wrr_lock_arbiter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int WEIGHT_W = 3
);
    localparam int IDX_W = clog2(WIDTH);

    logic [WIDTH-1:0]          request;
    logic                      ack;
    logic [WIDTH*WEIGHT_W-1:0] weight;
    logic [WIDTH-1:0]          grant;
    logic                      grant_valid;
    logic [IDX_W-1:0]          grant_idx;
    logic [WEIGHT_W-1:0]       credit_left;

    modport master (
        output request, ack, weight,
        input  grant, grant_valid, grant_idx, credit_left
    );

    modport slave (
        input  request, ack, weight,
        output grant, grant_valid, grant_idx, credit_left
    );
endinterface

// File: rtl/wrr_lock_arbiter_rr_pick.sv
// Combinational rotating-priority picker.
//   req       : request vector
//   start_idx : highest-priority position; scan wraps at WIDTH-1
//   found     : at least one request set
//   pick_idx  : first set request at or after start_idx (0 when none)
module wrr_lock_arbiter_rr_pick
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] start_idx,
    output logic             found,
    output logic [IDX_W-1:0] pick_idx
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

    logic [IDX_W-1:0] cand;

    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        cand     = start_idx;
        for (int k = 0; k < WIDTH; k++) begin
            if (!found && req[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
            // Explicit wrap so WIDTH need not be a power of two.
            cand = (cand == LAST) ? '0 : cand + IDX_W'(1);
        end
    end
endmodule

// File: rtl/wrr_lock_arbiter.sv
// Weighted round-robin arbiter with grant lock.
//   clk    : rising-edge clock
//   resetb : synchronous active-low reset
//   bus    : arbiter side of wrr_lock_arbiter_if
// A grant holds until ack; each requester gets up to weight[i] acked
// transactions per turn, and the next grant is issued in the ack cycle.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_IDLE  | no grant; arbitrate from ptr when any request
//   ST_GRANT | grant locked to grant_idx until ack
module wrr_lock_arbiter
    import wrr_lock_arbiter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int WEIGHT_W = 3
) (
    input logic             clk,
    input logic             resetb,
    wrr_lock_arbiter_if.slave bus
);
    localparam int               IDX_W = clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(WIDTH - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0]    grant_q, grant_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic                valid_q;

    logic [IDX_W-1:0]          idx_inc;
    logic [IDX_W-1:0]          start_idx;
    logic                      found;
    logic [IDX_W-1:0]          pick_idx;
    logic [WEIGHT_VEC_MAX-1:0] weight_ext;
    logic [WEIGHT_W-1:0]       credit_load;
    logic                      burst_continue;

    assign idx_inc    = (idx_q == LAST) ? '0 : idx_q + IDX_W'(1);
    // One picker serves both paths: from ptr when idle, from idx+1 on release.
    assign start_idx  = (state_q == ST_GRANT) ? idx_inc : ptr_q;
    assign weight_ext = WEIGHT_VEC_MAX'(bus.weight);
    assign credit_load = WEIGHT_W'(weight_field(weight_ext, int'(pick_idx), WEIGHT_W));
    assign burst_continue = (credit_q > WEIGHT_W'(1)) && bus.request[idx_q];

    wrr_lock_arbiter_rr_pick #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_pick (
        .req       (bus.request),
        .start_idx (start_idx),
        .found     (found),
        .pick_idx  (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        grant_d  = grant_q;
        credit_d = credit_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d  = ST_GRANT;
                    idx_d    = pick_idx;
                    grant_d  = WIDTH'(1) << pick_idx;
                    credit_d = credit_load;
                end
            end
            ST_GRANT: begin
                if (bus.ack) begin
                    if (burst_continue) begin
                        credit_d = credit_q - WEIGHT_W'(1);
                    end else begin
                        ptr_d = idx_inc;
                        if (found) begin
                            idx_d    = pick_idx;
                            grant_d  = WIDTH'(1) << pick_idx;
                            credit_d = credit_load;
                        end else begin
                            state_d  = ST_IDLE;
                            grant_d  = '0;
                            credit_d = '0;
                        end
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                grant_d  = '0;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            grant_q  <= '0;
            credit_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            grant_q  <= grant_d;
            credit_q <= credit_d;
            valid_q  <= |grant_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = valid_q;
    assign bus.grant_idx   = idx_q;
    assign bus.credit_left = credit_q;
endmodule
